// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared state encoding, pin levels and counter sizing for sram_ctrl
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    // Active-low strobes: PIN_OFF is the level that leaves the SRAM deselected.
    localparam logic PIN_OFF = 1'b1;
    localparam logic PIN_ON  = 1'b0;

    localparam int WAIT_CYCLES_DEFAULT = 2;
    localparam int WAIT_W              = $clog2(WAIT_CYCLES_DEFAULT + 1);

    function automatic int wait_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - request port and pad-side signals of sram_ctrl
interface sram_ctrl_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 4
);
    logic                  i_req;
    logic                  i_write;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic [LEN_WIDTH-1:0]  i_len;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_rdata;
    logic                  o_rvalid;
    logic                  o_wack;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_data_oe;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_n_ce;
    logic                  o_n_oe;
    logic                  o_n_we;

    modport master (
        output i_req, i_write, i_addr, i_wdata, i_len, i_data,
        input  o_ready, o_rdata, o_rvalid, o_wack, o_addr, o_data, o_data_oe,
               o_n_ce, o_n_oe, o_n_we
    );

    modport slave (
        input  i_req, i_write, i_addr, i_wdata, i_len, i_data,
        output o_ready, o_rdata, o_rvalid, o_wack, o_addr, o_data, o_data_oe,
               o_n_ce, o_n_oe, o_n_we
    );
endinterface

// File: rtl/sram_wait_timer.sv
// rtl/sram_wait_timer.sv - loadable down-counter, done high on the last cycle of the count
module sram_wait_timer
    import sram_pkg::*;
#(
    parameter int CYCLES = WAIT_CYCLES_DEFAULT,
    parameter int WIDTH  = wait_width(CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);
    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= WIDTH'(CYCLES);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == WIDTH'(1));
endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - async SRAM controller with wait states and write setup/hold;
// incrementing read bursts are built only when SRAM_BURST_READ_EN is defined.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2,
    parameter int LEN_WIDTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    sram_ctrl_if.slave  bus
);
    state_t state;
    logic   is_write;
    logic   done;
    logic   load;
    logic   more;

    assign bus.o_ready = (state == IDLE);

`ifdef SRAM_BURST_READ_EN
    logic [LEN_WIDTH-1:0] beats;

    assign more = (beats != '0);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            beats <= '0;
        end else if (state == IDLE && bus.i_req) begin
            beats <= bus.i_len;
        end else if (state == ACCESS && done && !is_write && more) begin
            beats <= beats - 1'b1;
        end
    end
`else
    logic unused_len;
    assign unused_len = ^bus.i_len[LEN_WIDTH-1:0];
    assign more       = 1'b0;
`endif

    // Reload on entry to ACCESS and again between burst beats so each beat gets a full window.
    assign load = (state == SETUP) || (state == ACCESS && done && !is_write && more);

    sram_wait_timer #(.CYCLES(WAIT_CYCLES)) u_timer (
        .clk  (i_clk),
        .rst  (i_reset),
        .load (load),
        .done (done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state         <= IDLE;
            is_write      <= 1'b0;
            bus.o_addr    <= ADDR_WIDTH'(0);
            bus.o_data    <= DATA_WIDTH'(0);
            bus.o_rdata   <= DATA_WIDTH'(0);
            bus.o_data_oe <= 1'b0;
            bus.o_rvalid  <= 1'b0;
            bus.o_wack    <= 1'b0;
            bus.o_n_ce    <= PIN_OFF;
            bus.o_n_oe    <= PIN_OFF;
            bus.o_n_we    <= PIN_OFF;
        end else begin
            bus.o_rvalid <= 1'b0;
            bus.o_wack   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_req) begin
                        is_write   <= bus.i_write;
                        bus.o_addr <= bus.i_addr;
                        bus.o_n_ce <= PIN_ON;
                        if (bus.i_write) begin
                            bus.o_data    <= bus.i_wdata;
                            bus.o_data_oe <= 1'b1;
                        end else begin
                            bus.o_n_oe <= PIN_ON;
                        end
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (is_write) begin
                        bus.o_n_we <= PIN_ON;
                    end
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        if (is_write) begin
                            bus.o_n_we <= PIN_OFF;
                            state      <= HOLD;
                        end else begin
                            bus.o_rdata  <= bus.i_data;
                            bus.o_rvalid <= 1'b1;
                            if (more) begin
                                bus.o_addr <= bus.o_addr + ADDR_WIDTH'(1);
                            end else begin
                                bus.o_n_ce <= PIN_OFF;
                                bus.o_n_oe <= PIN_OFF;
                                state      <= IDLE;
                            end
                        end
                    end
                end
                HOLD: begin
                    bus.o_wack    <= 1'b1;
                    bus.o_n_ce    <= PIN_OFF;
                    bus.o_data_oe <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - self-checking bench for sram_ctrl with an SRAM pad model and reference memory
module tb_sram_ctrl;
    localparam int AW  = 20;
    localparam int DW  = 8;
    localparam int W   = 2;
    localparam int LW  = 4;
    localparam int CLK = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    sram_ctrl #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .WAIT_CYCLES (W),
        .LEN_WIDTH   (LW)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [int];

    assign bus.i_data = (!bus.o_n_ce && !bus.o_n_oe) ? sram_mem[bus.o_addr] : 8'hEE;

    always @(posedge bus.o_n_we) begin
        if (!bus.o_n_ce && bus.o_data_oe) sram_mem[bus.o_addr] = bus.o_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) check("turnaround", {31'b0, bus.o_data_oe & ~bus.o_n_oe}, 32'd0);
    end

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
    endfunction

    function automatic int beats_of(input int len);
`ifdef SRAM_BURST_READ_EN
        return len + 1;
`else
        return 1;
`endif
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (bus.o_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", {31'b0, bus.o_ready}, 32'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit poke);
        wait_ready();
        bus.i_req   = 1'b1;
        bus.i_write = 1'b1;
        bus.i_addr  = a;
        bus.i_wdata = d;
        bus.i_len   = LW'($urandom);
        @(posedge clk);
        #1;
        bus.i_req   = 1'b0;
        bus.i_addr  = AW'($urandom);
        bus.i_wdata = DW'($urandom);
        for (int c = 1; c <= W + 3; c++) begin
            @(negedge clk);
            check("wr_n_ce",    bus.o_n_ce,    (c <= W + 2) ? 0 : 1);
            check("wr_n_we",    bus.o_n_we,    (c >= 2 && c <= W + 1) ? 0 : 1);
            check("wr_data_oe", bus.o_data_oe, (c <= W + 2) ? 1 : 0);
            check("wr_n_oe",    bus.o_n_oe,    1);
            check("wr_wack",    bus.o_wack,    (c == W + 3) ? 1 : 0);
            check("wr_ready",   bus.o_ready,   (c == W + 3) ? 1 : 0);
            if (c <= W + 2) begin
                check("wr_addr", bus.o_addr, a);
                check("wr_data", bus.o_data, d);
            end
            if (poke) begin
                bus.i_req = (c >= 2 && c <= W + 1);
                if (bus.i_req) begin
                    bus.i_write = 1'b1;
                    bus.i_addr  = AW'($urandom);
                    bus.i_wdata = DW'($urandom);
                end
            end
        end
        ref_mem[int'(a)] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int len, output time t_acc);
        int nb   = beats_of(len);
        int last = W + 2 + (nb - 1) * W;
        logic [AW-1:0] ea;
        bit rv;
        wait_ready();
        bus.i_req   = 1'b1;
        bus.i_write = 1'b0;
        bus.i_addr  = a;
        bus.i_len   = LW'(len);
        bus.i_wdata = DW'($urandom);
        @(posedge clk);
        t_acc = $time;
        #1;
        bus.i_req  = 1'b0;
        bus.i_addr = AW'($urandom);
        bus.i_len  = LW'($urandom);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            rv = (c >= W + 2) && ((c - 2) % W == 0);
            check("rd_rvalid", bus.o_rvalid, rv);
            if (rv) begin
                ea = a + AW'((c - 2) / W - 1);
                check("rd_rdata", bus.o_rdata, ref_rd(ea));
            end
            check("rd_ready",   bus.o_ready,   (c == last) ? 1 : 0);
            check("rd_n_ce",    bus.o_n_ce,    (c == last) ? 1 : 0);
            check("rd_n_oe",    bus.o_n_oe,    (c == last) ? 1 : 0);
            check("rd_n_we",    bus.o_n_we,    1);
            check("rd_data_oe", bus.o_data_oe, 0);
            if (c < last) ea = a + AW'((c < 2) ? 0 : (c - 2) / W);
            else          ea = a + AW'(nb - 1);
            check("rd_addr", bus.o_addr, ea);
        end
    endtask

    initial begin
        logic [AW-1:0] waddr [8];
        time t0, t1;

        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 8'h00;

        bus.i_req   = 1'b1;
        bus.i_write = 1'b1;
        bus.i_addr  = 20'h0ABCD;
        bus.i_wdata = 8'hC3;
        bus.i_len   = '0;
        repeat (3) begin
            @(negedge clk);
            check("rst_n_ce",    bus.o_n_ce,    1);
            check("rst_n_we",    bus.o_n_we,    1);
            check("rst_n_oe",    bus.o_n_oe,    1);
            check("rst_data_oe", bus.o_data_oe, 0);
            check("rst_wack",    bus.o_wack,    0);
        end
        bus.i_req = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        check("init_ready",  bus.o_ready,  1);
        check("init_addr",   bus.o_addr,   0);
        check("init_data",   bus.o_data,   0);
        check("init_rdata",  bus.o_rdata,  0);
        check("init_rvalid", bus.o_rvalid, 0);
        check("init_wack",   bus.o_wack,   0);
        check("init_n_ce",   bus.o_n_ce,   1);
        check("init_n_oe",   bus.o_n_oe,   1);
        check("init_n_we",   bus.o_n_we,   1);

        do_write(20'h12345, 8'h5A, 1'b0);
        do_read(20'h12345, 0, t0);

        for (int i = 0; i < 8; i++) begin
            waddr[i] = AW'($urandom);
            do_write(waddr[i], DW'($urandom), i[0]);
        end
        for (int i = 0; i < 8; i++) begin
            do_read(waddr[$urandom_range(0, 7)], $urandom_range(0, 3), t0);
        end

        do_write(20'hFFFFE, 8'h11, 1'b0);
        do_write(20'hFFFFF, 8'h22, 1'b0);
        do_write(20'h00000, 8'h33, 1'b0);
        do_write(20'h00001, 8'h44, 1'b0);
        do_read(20'hFFFFE, 3, t0);

        for (int i = 0; i < 3; i++) begin
            do_read(waddr[i], 0, t0);
            do_read(waddr[i + 1], 0, t1);
            check("b2b_spacing", 32'(t1 - t0), (W + 2) * CLK);
        end

        waddr[0] = AW'($urandom);
        do_write(waddr[0], 8'hA7, 1'b1);
        do_read(waddr[0], 0, t0);

        wait_ready();
        bus.i_req   = 1'b1;
        bus.i_write = 1'b1;
        bus.i_addr  = 20'h0ABCD;
        bus.i_wdata = 8'hC3;
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        @(posedge clk);
        #2;
        check("mw_n_we_low", bus.o_n_we, 0);
        rst = 1'b1;
        #1;
        check("mw_n_we",    bus.o_n_we,    1);
        check("mw_data_oe", bus.o_data_oe, 0);
        check("mw_n_ce",    bus.o_n_ce,    1);
        check("mw_ready",   bus.o_ready,   1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("mw_wack",   bus.o_wack,   0);
            check("mw_rvalid", bus.o_rvalid, 0);
            check("mw_idle",   bus.o_n_ce,   1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised controller for an external asynchronous SRAM (default 1M×8) with a valid/ready request port toward the requesting logic, and registered, glitch-free chip pins. It sits between user logic and the top-level pads. The top level owns the tristate buffer, driving the data bus from `o_data`/`o_data_oe` and returning it on `i_data`. It adds programmable wait states, separate write setup and hold phases, and optional incrementing read bursts.

## Interface
- `ADDR_WIDTH`, 20, SRAM address bits
- `DATA_WIDTH`, 8, SRAM data bits
- `WAIT_CYCLES`, 2, clocks in the access phase (≥1); sized so WAIT_CYCLES×Tclk ≥ tAA/tWP
- `LEN_WIDTH`, 4, burst length field width

- `i_clk`  in  1  the single clock
- `i_reset`  in  1  asynchronous, active-high reset
- `i_req`  in  1  request valid
- `i_write`  in  1  1 = write, 0 = read
- `i_addr`  in  ADDR_WIDTH  start address
- `i_wdata`  in  DATA_WIDTH  write data
- `i_len`  in  LEN_WIDTH  read beats minus one
- `o_ready`  out  1  controller idle; request accepted on edge where `i_req & o_ready`
- `o_rdata`  out  DATA_WIDTH  read data, valid with `o_rvalid`
- `o_rvalid`  out  1  one-cycle pulse per read beat
- `o_wack`  out  1  one-cycle pulse per completed write
- `o_addr`  out  ADDR_WIDTH  to pins
- `o_data`  out  DATA_WIDTH  to pad (write data)
- `o_data_oe`  out  1  pad output enable
- `i_data`  in  DATA_WIDTH  from pad
- `o_n_ce`, `o_n_oe`, `o_n_we`  out  1 each  active-low chip, output and write enables

## Operation
- **Outputs:** all outputs except `o_ready` are registered. `o_ready` = (state == IDLE).
- **Reset values:** `o_addr`, `o_data`, `o_rdata` = 0. `o_data_oe`, `o_rvalid`, `o_wack` = 0. `o_n_ce`, `o_n_oe`, `o_n_we` = 1. State = IDLE.
- **States:** IDLE, SETUP, ACCESS, HOLD.
- **IDLE:** all pins are inactive.
  - On accept, latch addr/wdata/write/len, drive `o_addr`, assert `o_n_ce`=0, and go to SETUP.
  - For a write, also drive `o_data` and set `o_data_oe`=1.
- **SETUP (1 cycle):**
  - Read: `o_n_oe`=0.
  - Write: `o_n_we` stays 1.
  - Load the wait counter with WAIT_CYCLES and go to ACCESS.
- **ACCESS (WAIT_CYCLES cycles):**
  - Read: `o_n_oe`=0. On the final cycle's edge, `o_rdata`←`i_data` and pulse `o_rvalid`. If beats remain, `o_addr`+1, decrement the beat count and reload the counter (stay in ACCESS, `o_n_oe` held low). Otherwise go to IDLE with pins inactive.
  - Write: `o_n_we`=0, then go to HOLD.
- **HOLD (1 cycle, write only):** `o_n_we`=1 while data and address are still driven. At its end, pulse `o_wack` and go to IDLE.
- **Request handling:** `i_req` while `o_ready`=0 is ignored. The requester holds its fields until accepted.
- **Address wrap:** the burst address wraps from 2^ADDR_WIDTH−1 to 0.
- **Reset mid-transfer:** pins go inactive immediately (asynchronously). The transfer is discarded and no `o_rvalid`/`o_wack` is produced.
- **Bus turnaround:** `o_data_oe` and `o_n_oe` are never both active.

## Timing
Accept edge = cycle 0; W = WAIT_CYCLES.
- **Single read:** SETUP in cycle 1, ACCESS in cycles 2..W+1. `o_rvalid` and `o_ready` are both high in cycle W+2, so back-to-back requests are possible every W+2 cycles.
- **Burst read:** beat k (0-based) has `o_rvalid` in cycle W+2+k·W.
- **Write:** SETUP in cycle 1, `o_n_we` low in cycles 2..W+1, HOLD in cycle W+2. `o_wack` and `o_ready` are high in cycle W+3.

## Configuration
- `SRAM_BURST_READ_EN`
  - **Defined:** reads perform `i_len`+1 incrementing beats.
  - **Undefined:** `i_len` is ignored, every read is a single beat, and the beat counter logic is not built.
- Writes are always single-beat in both builds.

## Structure
- **`sram_pkg`:**
  - state enum (IDLE/SETUP/ACCESS/HOLD)
  - pin-inactive constants
  - `WAIT_W = $clog2(WAIT_CYCLES+1)`
- **`sram_wait_timer`:** one natural sub-module, a loadable down-counter with a `done` flag on its last cycle.

## Test plan
- **Reset release:** all pins are inactive and `o_ready`=1. `i_req` asserted during reset produces no pin activity.
- **Write then read, W=2:** write 0x5A to 0x12345. `o_n_we` is low in cycles 2–3 and `o_wack` fires in cycle 5. A read of 0x12345 gives `o_rdata`=0x5A with `o_rvalid` in cycle 4.
- **Burst read (macro on):** `i_len`=3 at 0xFFFFE returns 4 beats from 0xFFFFE, 0xFFFFF, 0x00000 and 0x00001, with `o_rvalid` every 2 cycles.
- **Burst read (macro off):** the same stimulus gives exactly 1 `o_rvalid` and `o_addr` stays 0xFFFFE.
- **Busy and back-to-back:** `i_req` asserted while busy is ignored. Back-to-back reads complete one per W+2 cycles, and the bus-turnaround assertion never fires.
- **Reset mid-write:** reset asserted in cycle 2 of a write forces `o_n_we`=1 and `o_data_oe`=0 within the same cycle, and `o_wack` never fires.
